// File: rtl/mem_bist_initiator.sv
// BIST initiator: writes an address-derived pattern to every memory location, reads back and compares.
// Optional second inverted-pattern pass enabled by defining MEMTEST_INVERT_PASS_EN.
module mem_bist_initiator #(
   parameter int unsigned       ADDR_W = 9,
   parameter int unsigned       DATA_W = 8,
   parameter logic [DATA_W-1:0] SEED   = 8'h0A,
   parameter int unsigned       ERR_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_cs,
   output logic              mem_rw,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

`ifdef MEMTEST_INVERT_PASS_EN
   typedef enum logic [2:0] {IDLE, WRITE, READ, TAIL, DONE, SWAP} state_t;
`else
   typedef enum logic [2:0] {IDLE, WRITE, READ, TAIL, DONE} state_t;
`endif

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_cs;
   logic              r_rw;
   logic [DATA_W-1:0] r_wdata;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic [ERR_W-1:0]  r_err;
   logic [ADDR_W-1:0] r_first;
`ifdef MEMTEST_INVERT_PASS_EN
   logic              r_inv;
`endif

   logic              w_inv;
   logic              w_cmp;
   logic [ADDR_W-1:0] w_cmp_addr;
   logic              w_mismatch;
   logic [ERR_W-1:0]  w_err_next;

   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
      logic [DATA_W-1:0] lo;
      logic [DATA_W-1:0] s;
      lo  = DATA_W'(a);
      s   = SEED + lo;
      pat = s ^ {DATA_W{a[ADDR_W-1] ^ inv}};
   endfunction

`ifdef MEMTEST_INVERT_PASS_EN
   assign w_inv = r_inv;
`else
   assign w_inv = 1'b0;
`endif

   // Read data lags the issued address by one cycle; TAIL holds the last address.
   always_comb begin
      w_cmp      = ((r_state == READ) && (r_addr != '0)) || (r_state == TAIL);
      w_cmp_addr = (r_state == TAIL) ? r_addr : r_addr - 1'b1;
      w_mismatch = w_cmp && (mem_rdata != pat(w_cmp_addr, w_inv));
      w_err_next = r_err;
      if (w_mismatch && (r_err != '1))
         w_err_next = r_err + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_cs    <= 1'b0;
         r_rw    <= 1'b0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_err   <= '0;
         r_first <= '0;
`ifdef MEMTEST_INVERT_PASS_EN
         r_inv   <= 1'b0;
`endif
      end else begin
         r_err <= w_err_next;
         if (w_mismatch && (r_err == '0))
            r_first <= w_cmp_addr;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state <= WRITE;
                  r_addr  <= '0;
                  r_cs    <= 1'b1;
                  r_rw    <= 1'b1;
                  r_wdata <= pat('0, 1'b0);
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
                  r_err   <= '0;
                  r_first <= '0;
`ifdef MEMTEST_INVERT_PASS_EN
                  r_inv   <= 1'b0;
`endif
               end
            end
            WRITE: begin
               if (r_addr == '1) begin
                  r_addr  <= '0;
                  r_rw    <= 1'b0;
                  r_state <= READ;
               end else begin
                  r_addr  <= r_addr + 1'b1;
                  r_wdata <= pat(r_addr + 1'b1, w_inv);
               end
            end
            READ: begin
               if (r_addr == '1)
                  r_state <= TAIL;
               else
                  r_addr <= r_addr + 1'b1;
            end
            TAIL: begin
`ifdef MEMTEST_INVERT_PASS_EN
               if (!r_inv) begin
                  r_state <= SWAP;
                  r_cs    <= 1'b0;
                  r_addr  <= '0;
               end else begin
`else
               begin
`endif
                  r_state <= DONE;
                  r_cs    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == '0);
               end
            end
`ifdef MEMTEST_INVERT_PASS_EN
            SWAP: begin
               r_state <= WRITE;
               r_inv   <= 1'b1;
               r_cs    <= 1'b1;
               r_rw    <= 1'b1;
               r_wdata <= pat('0, 1'b1);
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_addr       = r_addr;
   assign mem_cs         = r_cs;
   assign mem_rw         = r_rw;
   assign mem_wdata      = r_wdata;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_count      = r_err;
   assign first_err_addr = r_first;

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Bench for mem_bist_initiator: behavioural byte memory with selectable read faults,
// table of full-test scenarios plus hand sequences for reset-abort and ignored starts.
module tb_mem_bist_initiator;

`ifdef MEMTEST_INVERT_PASS_EN
   localparam int NP = 2;
`else
   localparam int NP = 1;
`endif
   localparam int DEPTH = 512;
   localparam int DONE_CYC = (NP == 2) ? 4*DEPTH+4 : 2*DEPTH+2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [8:0] mem_addr;
   logic       mem_cs;
   logic       mem_rw;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic       busy;
   logic       done;
   logic       pass;
   logic [9:0] err_count;
   logic [8:0] first_err_addr;

   mem_bist_initiator #(.ADDR_W(9), .DATA_W(8), .SEED(8'h0A), .ERR_W(10)) dut (
      .clk(clk), .reset(reset), .start(start),
      .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_rw(mem_rw),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_addr(first_err_addr)
   );

   always #5 clk = ~clk;

   // fault mode: 0 good, 1 flip bit0 when reading 0x1F5, 2 bit0 stuck at 0
   int         mode = 0;
   logic [7:0] mem [0:DEPTH-1];
   int         wr_cnt = 0;
   logic [7:0] rd_val;

   always_comb begin
      rd_val = mem[mem_addr];
      if (mode == 1 && mem_addr == 9'h1F5) rd_val = rd_val ^ 8'h01;
      if (mode == 2) rd_val = rd_val & 8'hFE;
   end

   always @(posedge clk) begin
      if (mem_cs && mem_rw) begin
         mem[mem_addr] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (mem_cs) mem_rdata <= rd_val;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b0;
      @(posedge clk);
      @(negedge clk); reset = 1'b1;
   endtask

   // Pulses start (sampled at edge 0); optional extra starts sampled at edges xs0/xs1.
   // Returns the cycle in which done is first seen (cycle n follows edge n-1), or -1.
   task automatic run(input int xs0, input int xs1, output int dcyc);
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      dcyc = -1;
      for (int e = 1; e < 6000; e++) begin
         if (e == xs0 || e == xs1) start = 1'b1;
         @(posedge clk);
         @(negedge clk); start = 1'b0;
         if (done) begin
            dcyc = e + 1;
            break;
         end
      end
   endtask

   typedef struct {
      string name;
      int    mode;
      int    pass;
      int    err;
      int    first;
   } vec_t;

   vec_t vecs [3];
   int   dcyc;
   int   base;

   initial begin
      vecs[0] = '{"good",    0, 1, 0,        9'h000};
      vecs[1] = '{"corrupt", 1, 0, NP,       9'h1F5};
      vecs[2] = '{"stuck0",  2, 0, 256 * NP, 9'h001};

      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cs", mem_cs, 0);
      check("rst_rw", mem_rw, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_count, 0);
      check("rst_first", first_err_addr, 0);
      reset = 1'b1;

      for (int i = 0; i < 3; i++) begin
         mode = vecs[i].mode;
         base = wr_cnt;
         run(-1, -1, dcyc);
         check({vecs[i].name, "_done_cyc"}, dcyc, DONE_CYC);
         check({vecs[i].name, "_pass"}, pass, vecs[i].pass);
         check({vecs[i].name, "_err"}, err_count, vecs[i].err);
         check({vecs[i].name, "_first"}, first_err_addr, vecs[i].first);
         check({vecs[i].name, "_busy"}, busy, 0);
         check({vecs[i].name, "_writes"}, wr_cnt - base, DEPTH * NP);
         check({vecs[i].name, "_mem000"}, mem[0], (NP == 2) ? 8'hF5 : 8'h0A);
         check({vecs[i].name, "_mem100"}, mem[256], (NP == 2) ? 8'h0A : 8'hF5);
      end

      // done is held in DONE until a new start
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("done_held", done, 1);

      // first write cycles, then reset mid-WRITE together with a start
      mode = 0;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      check("w0_cs", mem_cs, 1);
      check("w0_rw", mem_rw, 1);
      check("w0_addr", mem_addr, 0);
      check("w0_wdata", mem_wdata, 8'h0A);
      check("w0_busy", busy, 1);
      check("w0_done", done, 0);
      check("w0_err_clr", err_count, 0);
      @(posedge clk);
      @(negedge clk);
      check("w1_addr", mem_addr, 1);
      check("w1_wdata", mem_wdata, 8'h0B);
      repeat (297) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1; start = 1'b0;
      check("abort_cs", mem_cs, 0);
      check("abort_rw", mem_rw, 0);
      check("abort_addr", mem_addr, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_err", err_count, 0);
      @(posedge clk);
      @(negedge clk);
      check("abort_idle", busy, 0);
      run(-1, -1, dcyc);
      check("after_abort_done_cyc", dcyc, DONE_CYC);
      check("after_abort_pass", pass, 1);

      // starts while busy are ignored
      mode = 1;
      run(10, 600, dcyc);
      check("xstart_done_cyc", dcyc, DONE_CYC);
      check("xstart_err", err_count, NP);
      check("xstart_first", first_err_addr, 9'h1F5);
      check("xstart_pass", pass, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
